// File: rtl/dmem_arbiter_if.sv
// Data-memory bus shared by the CPU data port, host/DMA port and RAM.
// slave is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_req;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [3:0]  host_wen;
  logic        host_lock;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        host_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wen;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_wen,
    output cpu_rdata, cpu_stall,
    input  host_req, host_addr, host_wdata, host_wen, host_lock,
    output host_gnt, host_rvalid, host_rdata, host_err,
    output mem_addr, mem_wdata, mem_wen,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_wen,
    input  cpu_rdata, cpu_stall,
    output host_req, host_addr, host_wdata, host_wen, host_lock,
    input  host_gnt, host_rvalid, host_rdata, host_err,
    input  mem_addr, mem_wdata, mem_wen,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter for the single data-memory port, with host
// starvation guard and bounded host burst lock.
module dmem_arbiter #(
  parameter int MEM_WORDS    = 1024,
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input logic          clk,
  input logic          rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [31:0]   ADDR_END = 32'(4 * MEM_WORDS);
  localparam logic [SW-1:0] S_MAX    = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] B_MAX    = BW'(BURST_MAX);

  typedef enum logic {S_CPU, S_HOST} state_t;

  state_t        state, state_n;
  logic [SW-1:0] starve_cnt, starve_n;
  logic [BW-1:0] burst_cnt, burst_n;
  logic          grant_host;
  logic          cpu_own;
  logic          cpu_ok;
  logic          host_ok;
  logic          host_rd;

  function automatic logic acc_ok(logic [31:0] a, logic [3:0] w);
    return (a < ADDR_END) && !((a[1:0] != 2'b00) && (w == 4'hF));
  endfunction

  assign cpu_ok  = acc_ok(bus.cpu_addr, bus.cpu_wen);
  assign host_ok = acc_ok(bus.host_addr, bus.host_wen);
  assign host_rd = (bus.host_wen == 4'h0);

  always_comb begin
    state_n    = state;
    starve_n   = starve_cnt;
    burst_n    = burst_cnt;
    grant_host = 1'b0;
    if (rst_n) begin
      unique case (state)
        S_CPU: begin
          grant_host = bus.host_req &&
                       (!bus.cpu_req || starve_cnt == S_MAX);
          if (grant_host && bus.host_lock && BURST_MAX > 1) begin
            state_n = S_HOST;
            burst_n = BW'(1);
          end
        end
        S_HOST: begin
          grant_host = bus.host_req;
          burst_n    = burst_cnt + BW'(grant_host);
          // burst ends here; the next cycle is always CPU-priority
          if (!bus.host_req || !bus.host_lock || burst_n == B_MAX) begin
            state_n = S_CPU;
            burst_n = '0;
          end
        end
        default: state_n = S_CPU;
      endcase
      if (bus.host_req && !grant_host)
        starve_n = (starve_cnt == S_MAX) ? S_MAX : starve_cnt + 1'b1;
      else
        starve_n = '0;
    end
  end

  assign cpu_own       = rst_n && bus.cpu_req && !grant_host;
  assign bus.host_gnt  = grant_host;
  assign bus.cpu_stall = bus.cpu_req && grant_host;
  assign bus.cpu_rdata = (cpu_own && cpu_ok) ? bus.mem_rdata : '0;

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wen   = '0;
    unique case (1'b1)
      grant_host: begin
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
        bus.mem_wen   = host_ok ? bus.host_wen : 4'h0;
      end
      cpu_own: begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_wen   = cpu_ok ? bus.cpu_wen : 4'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_CPU;
      starve_cnt      <= '0;
      burst_cnt       <= '0;
      bus.host_rvalid <= 1'b0;
      bus.host_err    <= 1'b0;
      bus.host_rdata  <= '0;
    end else begin
      state           <= state_n;
      starve_cnt      <= starve_n;
      burst_cnt       <= burst_n;
      bus.host_rvalid <= grant_host && host_rd;
      bus.host_err    <= grant_host && !host_ok;
      if (grant_host && host_rd)
        bus.host_rdata <= host_ok ? bus.mem_rdata : 32'hDEAD_BEEF;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus starvation,
// burst and mid-burst reset sequences against a small RAM model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic ram_clr;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] ram [1024];

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      ram[32'h500 >> 2] <= 32'h0000_002A;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wen[b] && bus.mem_addr < 32'h1000)
          ram[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  assign bus.mem_rdata = (bus.mem_addr < 32'h1000) ?
                         ram[bus.mem_addr[11:2]] : 32'h0;

  typedef struct {
    logic        creq;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic [3:0]  cwen;
    logic        hreq;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [3:0]  hwen;
    logic        gnt;
    logic        stall;
    logic [31:0] maddr;
    logic [3:0]  mwen;
    logic [31:0] crdata;
    logic        rvalid;
    logic        err;
    logic [31:0] hrdata;
  } vec_t;

  function automatic vec_t mk(
    logic creq, logic [31:0] caddr, logic [31:0] cwdata, logic [3:0] cwen,
    logic hreq, logic [31:0] haddr, logic [31:0] hwdata, logic [3:0] hwen,
    logic gnt, logic stall, logic [31:0] maddr, logic [3:0] mwen,
    logic [31:0] crdata, logic rvalid, logic err, logic [31:0] hrdata);
    vec_t v;
    v.creq = creq; v.caddr = caddr; v.cwdata = cwdata; v.cwen = cwen;
    v.hreq = hreq; v.haddr = haddr; v.hwdata = hwdata; v.hwen = hwen;
    v.gnt = gnt; v.stall = stall; v.maddr = maddr; v.mwen = mwen;
    v.crdata = crdata; v.rvalid = rvalid; v.err = err; v.hrdata = hrdata;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic idle_inputs();
    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_wen    = '0;
    bus.host_req   = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.host_wen   = '0;
    bus.host_lock  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[16];
  logic [31:0] exp_wd;
  int          gcyc[$];
  int          exp_g[6] = '{8, 9, 10, 11, 20, 21};
  int          n;
  int          idx;
  logic        got;

  initial begin
    vecs[0]  = mk(1, 'h400, 'h12345678, 'hF, 0, 0, 0, 0,
                  0, 0, 'h400, 'hF, 0, 0, 0, 0);
    vecs[1]  = mk(1, 'h400, 0, 0, 0, 0, 0, 0,
                  0, 0, 'h400, 0, 'h12345678, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 'h500, 0, 0,
                  1, 0, 'h500, 0, 0, 1, 0, 'h2A);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 'h400, 0, 0, 1, 'h500, 0, 0,
                  0, 0, 'h400, 0, 'h12345678, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 'h504, 'hCAFEF00D, 'hF,
                  1, 0, 'h504, 'hF, 0, 0, 0, 0);
    vecs[6]  = mk(1, 'h504, 0, 0, 0, 0, 0, 0,
                  0, 0, 'h504, 0, 'hCAFEF00D, 0, 0, 0);
    vecs[7]  = mk(1, 'h402, 'h11111111, 'hF, 0, 0, 0, 0,
                  0, 0, 'h402, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 'h402, 'h00AB0000, 'h4, 0, 0, 0, 0,
                  0, 0, 'h402, 'h4, 'h12345678, 0, 0, 0);
    vecs[9]  = mk(1, 'h400, 0, 0, 0, 0, 0, 0,
                  0, 0, 'h400, 0, 'h12AB5678, 0, 0, 0);
    vecs[10] = mk(1, 'h1000, 0, 0, 0, 0, 0, 0,
                  0, 0, 'h1000, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 1, 'h1000, 'h77777777, 'hF,
                  1, 0, 'h1000, 0, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 'h1004, 0, 0,
                  1, 0, 'h1004, 0, 0, 1, 1, 'hDEADBEEF);
    vecs[13] = mk(0, 0, 0, 0, 1, 'h501, 0, 0,
                  1, 0, 'h501, 0, 0, 1, 0, 'h2A);
    vecs[14] = mk(0, 0, 0, 0, 1, 'h502, 'h99999999, 'hF,
                  1, 0, 'h502, 0, 0, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0);

    // reset with both requesters active
    idle_inputs();
    ram_clr = 1'b1;
    rst_n   = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h400;
    bus.cpu_wen  = 4'hF;
    bus.host_req = 1'b1;
    bus.host_addr = 32'h500;
    repeat (3) next_cycle();
    chk("rst_gnt", bus.host_gnt, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_mwen", bus.mem_wen, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_rvalid", bus.host_rvalid, 0);
    chk("rst_err", bus.host_err, 0);
    chk("rst_hrdata", bus.host_rdata, 0);
    idle_inputs();
    ram_clr = 1'b0;
    #3;
    rst_n = 1'b1;
    next_cycle();

    // table vectors, one cycle each
    for (int i = 0; i < 16; i++) begin
      bus.cpu_req    = vecs[i].creq;
      bus.cpu_addr   = vecs[i].caddr;
      bus.cpu_wdata  = vecs[i].cwdata;
      bus.cpu_wen    = vecs[i].cwen;
      bus.host_req   = vecs[i].hreq;
      bus.host_addr  = vecs[i].haddr;
      bus.host_wdata = vecs[i].hwdata;
      bus.host_wen   = vecs[i].hwen;
      bus.host_lock  = 1'b0;
      exp_wd = vecs[i].gnt ? vecs[i].hwdata :
               (vecs[i].creq ? vecs[i].cwdata : 32'h0);
      #3;
      chk($sformatf("v%0d_gnt", i), bus.host_gnt, vecs[i].gnt);
      chk($sformatf("v%0d_stall", i), bus.cpu_stall, vecs[i].stall);
      chk($sformatf("v%0d_maddr", i), bus.mem_addr, vecs[i].maddr);
      chk($sformatf("v%0d_mwen", i), bus.mem_wen, vecs[i].mwen);
      chk($sformatf("v%0d_mwdata", i), bus.mem_wdata, exp_wd);
      chk($sformatf("v%0d_crdata", i), bus.cpu_rdata, vecs[i].crdata);
      next_cycle();
      chk($sformatf("v%0d_rvalid", i), bus.host_rvalid, vecs[i].rvalid);
      chk($sformatf("v%0d_err", i), bus.host_err, vecs[i].err);
      if (vecs[i].rvalid)
        chk($sformatf("v%0d_hrdata", i), bus.host_rdata, vecs[i].hrdata);
    end

    // starvation: CPU requests every cycle, host waits 8 cycles
    idle_inputs();
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 32'h400;
    bus.host_req  = 1'b1;
    bus.host_addr = 32'h500;
    for (int k = 0; k <= 8; k++) begin
      #3;
      chk($sformatf("starve%0d_gnt", k), bus.host_gnt, k == 8);
      chk($sformatf("starve%0d_stall", k), bus.cpu_stall, k == 8);
      next_cycle();
    end
    chk("starve_rvalid", bus.host_rvalid, 1);
    chk("starve_hrdata", bus.host_rdata, 32'h2A);
    bus.host_addr = 32'h400;
    n   = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #3;
      if (bus.host_gnt) begin
        got = 1'b1;
        n   = k;
      end
      next_cycle();
      if (k == 0) chk("rvalid_pulse", bus.host_rvalid, 0);
    end
    chk("restarve_got", got, 1);
    chk("restarve_cycle", 32'(n), 32'd8);
    chk("restarve_hrdata", bus.host_rdata, 32'h12AB5678);
    bus.host_req = 1'b0;
    next_cycle();

    // locked burst of six host writes against a busy CPU
    bus.host_lock = 1'b1;
    bus.host_wen  = 4'hF;
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      bus.host_req   = 1'b1;
      bus.host_addr  = 32'h420 + 32'(4 * idx);
      bus.host_wdata = 32'hB000_0000 + 32'(idx);
      #3;
      chk($sformatf("burst_c%0d_stall", c), bus.cpu_stall, bus.host_gnt);
      if (bus.host_gnt) begin
        gcyc.push_back(c);
        chk($sformatf("burst_g%0d_maddr", idx), bus.mem_addr,
            32'h420 + 32'(4 * idx));
        chk($sformatf("burst_g%0d_mwen", idx), bus.mem_wen, 4'hF);
        idx++;
      end
      next_cycle();
    end
    bus.host_req  = 1'b0;
    bus.host_lock = 1'b0;
    #3;
    chk("burst_end_stall", bus.cpu_stall, 0);
    chk("burst_ngrants", 32'(gcyc.size()), 32'd6);
    for (int g = 0; g < 6; g++) begin
      if (g < gcyc.size())
        chk($sformatf("burst_gcyc%0d", g), 32'(gcyc[g]), 32'(exp_g[g]));
      chk($sformatf("burst_ram%0d", g), ram[(32'h420 >> 2) + g],
          32'hB000_0000 + 32'(g));
    end
    next_cycle();

    // reset in the second cycle of a burst
    idle_inputs();
    bus.host_lock = 1'b1;
    bus.host_req  = 1'b1;
    bus.host_addr = 32'h500;
    #3;
    chk("rb0_gnt", bus.host_gnt, 1);
    next_cycle();
    bus.host_addr  = 32'h444;
    bus.host_wdata = 32'h5555_AAAA;
    bus.host_wen   = 4'hF;
    #3;
    chk("rb1_gnt", bus.host_gnt, 1);
    chk("rb1_mwen", bus.mem_wen, 4'hF);
    chk("rb1_rvalid", bus.host_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rbr_gnt", bus.host_gnt, 0);
    chk("rbr_mwen", bus.mem_wen, 0);
    chk("rbr_maddr", bus.mem_addr, 0);
    chk("rbr_rvalid", bus.host_rvalid, 0);
    chk("rbr_hrdata", bus.host_rdata, 0);
    next_cycle();
    chk("rbr_no_write", ram[32'h444 >> 2], 32'h0);
    idle_inputs();
    #3;
    rst_n = 1'b1;
    next_cycle();
    chk("rba_rvalid", bus.host_rvalid, 0);
    chk("rba_err", bus.host_err, 0);
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 32'h400;
    bus.host_req  = 1'b1;
    bus.host_addr = 32'h500;
    #3;
    chk("rba_cpu_prio_gnt", bus.host_gnt, 0);
    chk("rba_cpu_prio_stall", bus.cpu_stall, 0);
    chk("rba_cpu_rdata", bus.cpu_rdata, 32'h12AB5678);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter for the single data-memory port.
- The CPU data port and a host/DMA port share the RAM. The host port is used by the loader, result dump and FFT buffer fill.
- Sits between `cpu_top` data signals and the RAM model, which has a combinational read.
- The CPU has default priority. A starvation counter and a bounded host burst lock guarantee host progress.
- `cpu_stall` freezes the CPU in any cycle it loses the port.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; valid byte addresses are 0 .. 4*MEM_WORDS-1.
- STARVE_LIMIT, 8: consecutive denied host cycles before a forced host grant; must be ≥1.
- BURST_MAX, 4: maximum consecutive host grants under `host_lock`; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU issues a load/store this cycle
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_wen  in  4  CPU byte write enables; 0 means read
- cpu_rdata  out  32  CPU load data, combinational
- cpu_stall  out  1  CPU access not serviced this cycle; CPU must hold its request
- host_req  in  1  host request; held until granted
- host_addr  in  32  host byte address
- host_wdata  in  32  host write data
- host_wen  in  4  host byte enables; 0 means read
- host_lock  in  1  host requests burst ownership
- host_gnt  out  1  host access performed this cycle, combinational
- host_rvalid  out  1  registered pulse, one cycle after a granted host read
- host_rdata  out  32  registered host read data
- host_err  out  1  registered pulse, one cycle after a granted out-of-range or misaligned host access
- mem_addr  out  32  RAM byte address
- mem_wdata  out  32  RAM write data
- mem_wen  out  4  RAM byte write enables
- mem_rdata  in  32  RAM read data, combinational from `mem_addr`

Behaviour:
- Reset (async, rst_n=0):
  - State is S_CPU; `starve_cnt`=0, `burst_cnt`=0.
  - `host_rvalid`=0, `host_err`=0, `host_rdata`=0.
  - While reset is asserted, `host_gnt`=0, `cpu_stall`=0, `mem_wen`=0 and `mem_addr`=0.
- States:
  - S_CPU: CPU priority.
  - S_HOST: host burst ownership.
- Grant in S_CPU:
  - `grant_host` = `host_req` && (!`cpu_req` || `starve_cnt`==STARVE_LIMIT).
  - `grant_host` && `host_lock` && `host_req` enters S_HOST next cycle with `burst_cnt`=1.
- Grant in S_HOST:
  - `grant_host` = `host_req`.
  - Each grant increments `burst_cnt`.
  - Return to S_CPU when `host_req`=0, or `host_lock`=0, or after the BURST_MAX-th grant.
  - After a burst ends, the first following cycle is CPU-priority even if `host_lock` stays high (no back-to-back bursts).
- Starvation counter (`starve_cnt`):
  - Increments on each cycle with `host_req`=1 && !`grant_host`.
  - Clears on a grant or when `host_req`=0.
  - Saturates at STARVE_LIMIT.
- `cpu_stall` = `cpu_req` && `grant_host`. `cpu_rdata` is driven from `mem_rdata` only when the CPU owns the port, otherwise 0.
- Mux:
  - `mem_addr`/`mem_wdata`/`mem_wen` come from the owner.
  - With no request, `mem_addr`=0, `mem_wdata`=0, `mem_wen`=0.
- Range and alignment check:
  - An access is invalid if addr ≥ 4*MEM_WORDS, or if addr[1:0]≠0 with `wen`=4'b1111.
  - An invalid access forces `mem_wen`=0.
  - Invalid CPU read returns `cpu_rdata`=0.
  - Invalid host access: `host_err` pulses next cycle. For a read, `host_rvalid` also pulses, with `host_rdata`=32'hDEADBEEF.
- Host read: data is captured at the grant edge. `host_rvalid`=1 for exactly one cycle after each granted read. Writes never raise `host_rvalid`.
- Simultaneous CPU and host writes to the same address: only the owner writes. The stalled CPU write lands on its next serviced cycle, after the host write.
- Mid-operation reset: asynchronously aborts the burst and clears pending pulses. No partial write occurs after `rst_n` falls.

Test Plan:
1. CPU only: store 0x12345678 to 0x400 → same cycle `mem_wen`=4'hF, `mem_addr`=0x400, `cpu_stall`=0. A subsequent load returns 0x12345678.
2. Host read with CPU idle: `host_req` at 0x500 (RAM holds 0x0000002A) → `host_gnt`=1 same cycle. Next cycle `host_rvalid`=1 and `host_rdata`=0x2A, then `host_rvalid`=0.
3. Starvation: `cpu_req` held 1 continuously; `host_req` asserted at cycle 0 → `host_gnt` first at cycle 8. `cpu_stall`=1 only in cycle 8; `starve_cnt` returns to 0.
4. Burst: `host_lock`=1 with 6 queued host writes (0x420..0x434) while `cpu_req`=1 → 4 consecutive grants (after the starvation wait), then one CPU cycle, then host waits again with `starve_cnt` restarting.
5. Errors:
   - Host write 0x1000 with `wen`=4'hF → `mem_wen`=0 and `host_err` pulses next cycle; RAM is unchanged.
   - Host read 0x1004 → `host_rvalid`=1 with `host_rdata`=0xDEADBEEF.
6. Reset mid-burst: drop `rst_n` in the second burst cycle → `host_gnt`=0 and `mem_wen`=0 immediately. After release, state is S_CPU and `host_rvalid`=0.
